// File: rtl/fifo_bridge.sv
// Bridges a 6821-style PIA keyboard/display port pair onto an FT245 USB FIFO.
// One bus FSM owns the FT245 strobes; a small key FSM hands received bytes to the PIA.
module fifo_bridge #(
    parameter int DATA_W    = 7,
    parameter int RX_DEPTH  = 4,
    parameter int RD_CYCLES = 3,
    parameter int WR_CYCLES = 3,
    parameter int UCASE     = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      pia_ca2,
    input  logic                      pia_cb2,
    input  logic [DATA_W-1:0]         pia_pb,
    output logic [DATA_W-1:0]         pia_pa,
    output logic                      pia_ca1,
    output logic                      pia_da,
    input  logic                      fifo_rxf_n,
    input  logic                      fifo_txe_n,
    input  logic [7:0]                fifo_d_in,
    output logic [7:0]                fifo_d_out,
    output logic                      fifo_d_oe,
    output logic                      fifo_rd_n,
    output logic                      fifo_wr_n,
    output logic [$clog2(RX_DEPTH):0] rx_level
);

    localparam int PTR_W   = $clog2(RX_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

    typedef enum logic [2:0] {B_IDLE, B_RD, B_RGAP, B_WSETUP, B_WR, B_WHOLD} bus_state_t;
    typedef enum logic [1:0] {K_EMPTY, K_PRESENT, K_GAP} key_state_t;

    bus_state_t bus_state, bus_nx;
    key_state_t key_state, key_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic gap_cnt, gap_nx;
    logic [1:0] ca2_sync, cb2_sync, rxf_sync, txe_sync;
    logic ca2_prev, cb2_prev;
    logic ca2_rise, cb2_rise, rxf_ok, txe_ok;
    logic pending, rd_discard, write_req, full, push, pop;
    logic [7:0] disp_data, rx_byte;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic unused_bits;

    always_ff @(posedge clk) begin
        if (reset) begin
            ca2_sync <= 2'b00;
            cb2_sync <= 2'b00;
            rxf_sync <= 2'b11;
            txe_sync <= 2'b11;
            ca2_prev <= 1'b0;
            cb2_prev <= 1'b0;
        end else begin
            ca2_sync <= {ca2_sync[0], pia_ca2};
            cb2_sync <= {cb2_sync[0], pia_cb2};
            rxf_sync <= {rxf_sync[0], fifo_rxf_n};
            txe_sync <= {txe_sync[0], fifo_txe_n};
            ca2_prev <= ca2_sync[1];
            cb2_prev <= cb2_sync[1];
        end
    end

    assign ca2_rise = ca2_sync[1] & ~ca2_prev;
    assign cb2_rise = cb2_sync[1] & ~cb2_prev;
    assign rxf_ok   = ~rxf_sync[1];
    assign txe_ok   = ~txe_sync[1];
    assign full     = (rx_level == LVL_W'(RX_DEPTH));

    // A strobe arriving this cycle already counts as pending, so it beats a simultaneous read.
    assign write_req = (pending | cb2_rise) & txe_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= 1'b0;
            disp_data <= 8'h00;
        end else if (bus_state == B_WHOLD) begin
            pending <= 1'b0;
        end else if (cb2_rise && !pending) begin
            pending   <= 1'b1;
            disp_data <= 8'(pia_pb);
        end
    end

    assign pia_da     = pending;
    assign fifo_d_out = disp_data;

    always_comb begin
        rx_byte = fifo_d_in & 8'h7F;
        if (UCASE != 0 && rx_byte >= 8'h61 && rx_byte <= 8'h7A)
            rx_byte = rx_byte - 8'h20;
    end
    assign unused_bits = ^rx_byte;

    always_comb begin
        bus_nx = bus_state;
        cnt_nx = cnt;
        push   = 1'b0;
        case (bus_state)
            B_IDLE: begin
                cnt_nx = '0;
                if (write_req)
                    bus_nx = B_WSETUP;
                else if (rxf_ok && !full)
                    bus_nx = B_RD;
            end
            B_RD: begin
                if (cnt == RD_LAST) begin
                    bus_nx = B_RGAP;
                    cnt_nx = '0;
                    push   = !clear && !rd_discard;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            B_RGAP: begin
                if (cnt == RD_LAST) begin
                    bus_nx = B_IDLE;
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            B_WSETUP: begin
                bus_nx = B_WR;
                cnt_nx = '0;
            end
            B_WR: begin
                if (cnt == WR_LAST) begin
                    bus_nx = B_WHOLD;
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            B_WHOLD: bus_nx = B_IDLE;
            default: bus_nx = B_IDLE;
        endcase
    end

    // Strobes are registered from the next state so the FT245 never sees decode glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_state  <= B_IDLE;
            cnt        <= '0;
            fifo_rd_n  <= 1'b1;
            fifo_wr_n  <= 1'b1;
            fifo_d_oe  <= 1'b0;
            rd_discard <= 1'b0;
        end else begin
            bus_state <= bus_nx;
            cnt       <= cnt_nx;
            fifo_rd_n <= (bus_nx != B_RD);
            fifo_wr_n <= (bus_nx != B_WR);
            fifo_d_oe <= (bus_nx inside {B_WSETUP, B_WR, B_WHOLD});
            if (bus_state == B_IDLE)
                rd_discard <= 1'b0;
            else if (clear && bus_state == B_RD)
                rd_discard <= 1'b1;
        end
    end

    assign pop = (key_state == K_PRESENT) && ca2_rise && !clear && (rx_level != '0);

    always_ff @(posedge clk) begin
        if (push)
            rx_mem[wr_ptr] <= rx_byte[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_level <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   rx_level <= rx_level + 1'b1;
                2'b01:   rx_level <= rx_level - 1'b1;
                default: rx_level <= rx_level;
            endcase
        end
    end

    assign pia_pa = (rx_level != '0) ? rx_mem[rd_ptr] : '0;

    always_comb begin
        key_nx = key_state;
        gap_nx = gap_cnt;
        case (key_state)
            K_EMPTY: begin
                if (rx_level != '0)
                    key_nx = K_PRESENT;
            end
            K_PRESENT: begin
                if (ca2_rise) begin
                    key_nx = K_GAP;
                    gap_nx = 1'b0;
                end
            end
            K_GAP: begin
                if (gap_cnt)
                    key_nx = (rx_level != '0) ? K_PRESENT : K_EMPTY;
                else
                    gap_nx = 1'b1;
            end
            default: key_nx = K_EMPTY;
        endcase
        if (clear)
            key_nx = K_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_state <= K_EMPTY;
            gap_cnt   <= 1'b0;
            pia_ca1   <= 1'b0;
        end else begin
            key_state <= key_nx;
            gap_cnt   <= gap_nx;
            pia_ca1   <= (key_nx == K_PRESENT);
        end
    end

endmodule

// File: tb/tb_fifo_bridge.sv
// Directed self-checking bench for fifo_bridge at default parameters.
// Steps run back to back; each check is an immediate assertion that tallies failures.
module tb_fifo_bridge;

    logic       clk = 1'b0;
    logic       reset, clear, pia_ca2, pia_cb2;
    logic [6:0] pia_pb, pia_pa;
    logic       pia_ca1, pia_da;
    logic       fifo_rxf_n, fifo_txe_n;
    logic [7:0] fifo_d_in, fifo_d_out;
    logic       fifo_d_oe, fifo_rd_n, fifo_wr_n;
    logic [2:0] rx_level;

    int checks = 0;
    int errors = 0;

    fifo_bridge dut (
        .clk(clk), .reset(reset), .clear(clear),
        .pia_ca2(pia_ca2), .pia_cb2(pia_cb2), .pia_pb(pia_pb), .pia_pa(pia_pa),
        .pia_ca1(pia_ca1), .pia_da(pia_da),
        .fifo_rxf_n(fifo_rxf_n), .fifo_txe_n(fifo_txe_n),
        .fifo_d_in(fifo_d_in), .fifo_d_out(fifo_d_out), .fifo_d_oe(fifo_d_oe),
        .fifo_rd_n(fifo_rd_n), .fifo_wr_n(fifo_wr_n), .rx_level(rx_level)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One FT245 read of din; returns how many cycles rd_n was held low.
    task automatic doRead(input logic [7:0] din, output int low_cycles);
        int n;
        fifo_d_in  = din;
        fifo_rxf_n = 1'b0;
        n = 0;
        while (fifo_rd_n !== 1'b0 && n < 20) begin
            applyStimulus(1);
            n++;
        end
        fifo_rxf_n = 1'b1;
        low_cycles = 0;
        while (fifo_rd_n === 1'b0 && low_cycles < 10) begin
            low_cycles++;
            applyStimulus(1);
        end
        applyStimulus(6);
    endtask

    task automatic popKey();
        pia_ca2 = 1'b1;
        applyStimulus(3);
        pia_ca2 = 1'b0;
        applyStimulus(5);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, m, lows, reads, pulses, first_wr, first_rd, overlap;
        logic prev, wr_first;
        logic [7:0] heads [4];
        heads[0] = 8'h41; heads[1] = 8'h7B; heads[2] = 8'h60; heads[3] = 8'h5A;

        reset = 1'b1; clear = 1'b0; pia_ca2 = 1'b0; pia_cb2 = 1'b0; pia_pb = 7'h00;
        fifo_rxf_n = 1'b1; fifo_txe_n = 1'b1; fifo_d_in = 8'h00;
        applyStimulus(3);
        checkOutput("reset_rd_n", fifo_rd_n, 1);
        checkOutput("reset_wr_n", fifo_wr_n, 1);
        checkOutput("reset_oe", fifo_d_oe, 0);
        checkOutput("reset_d_out", fifo_d_out, 0);
        checkOutput("reset_ca1", pia_ca1, 0);
        checkOutput("reset_da", pia_da, 0);
        checkOutput("reset_pa", pia_pa, 0);
        checkOutput("reset_level", rx_level, 0);
        reset = 1'b0;
        applyStimulus(2);

        // Lowercase fold, bit-7 strip and FIFO ordering.
        doRead(8'h61, lows);
        checkOutput("read_low_cycles", lows, 3);
        checkOutput("read_pa_fold", pia_pa, 8'h41);
        checkOutput("read_ca1", pia_ca1, 1);
        checkOutput("read_level1", rx_level, 1);
        doRead(8'h7B, lows);
        doRead(8'h60, lows);
        doRead(8'hFA, lows);
        checkOutput("level_four", rx_level, 4);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("head_%0d", k), pia_pa, heads[k]);
            popKey();
        end
        checkOutput("drained_level", rx_level, 0);
        checkOutput("drained_pa", pia_pa, 0);
        checkOutput("drained_ca1", pia_ca1, 0);

        // Display write sequence.
        pia_pb = 7'h0B;
        pia_cb2 = 1'b1;
        applyStimulus(3);
        pia_cb2 = 1'b0;
        applyStimulus(2);
        checkOutput("disp_da_set", pia_da, 1);
        checkOutput("disp_d_out", fifo_d_out, 8'h0B);
        checkOutput("disp_idle_oe", fifo_d_oe, 0);
        fifo_txe_n = 1'b0;
        n = 0;
        while (fifo_d_oe !== 1'b1 && n < 10) begin
            applyStimulus(1);
            n++;
        end
        checkOutput("setup_oe", fifo_d_oe, 1);
        checkOutput("setup_wr_n", fifo_wr_n, 1);
        applyStimulus(1);
        lows = 0;
        while (fifo_wr_n === 1'b0 && lows < 10) begin
            lows++;
            applyStimulus(1);
        end
        checkOutput("wr_low_cycles", lows, 3);
        checkOutput("hold_oe", fifo_d_oe, 1);
        applyStimulus(1);
        checkOutput("after_hold_oe", fifo_d_oe, 0);
        checkOutput("after_hold_da", pia_da, 0);
        fifo_txe_n = 1'b1;
        applyStimulus(3);

        // Continuous receive stalls at a full buffer, resumes after one ack.
        fifo_d_in = 8'h35;
        fifo_rxf_n = 1'b0;
        reads = 0;
        prev = fifo_rd_n;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1);
            if (prev === 1'b1 && fifo_rd_n === 1'b0) reads++;
            prev = fifo_rd_n;
        end
        checkOutput("full_reads", reads, 4);
        checkOutput("full_level", rx_level, 4);
        checkOutput("full_rd_n_idle", fifo_rd_n, 1);
        checkOutput("full_pa", pia_pa, 8'h35);
        pia_ca2 = 1'b1;
        n = 0;
        while (pia_ca1 !== 1'b0 && n < 10) begin
            applyStimulus(1);
            n++;
        end
        pia_ca2 = 1'b0;
        m = 0;
        while (pia_ca1 === 1'b0 && m < 10) begin
            m++;
            applyStimulus(1);
        end
        checkOutput("ack_gap_cycles", m, 2);
        checkOutput("ack_ca1_back", pia_ca1, 1);
        n = 0;
        while (fifo_rd_n !== 1'b0 && n < 10) begin
            applyStimulus(1);
            n++;
        end
        checkOutput("fifth_read", fifo_rd_n, 0);
        checkOutput("pre_clear_level", rx_level, 3);

        // Clear lands mid-read.
        clear = 1'b1;
        fifo_rxf_n = 1'b1;
        applyStimulus(1);
        clear = 1'b0;
        checkOutput("clear_level", rx_level, 0);
        checkOutput("clear_ca1", pia_ca1, 0);
        checkOutput("clear_read_inflight", fifo_rd_n, 0);
        applyStimulus(10);
        checkOutput("discard_level", rx_level, 0);
        checkOutput("discard_pa", pia_pa, 0);
        checkOutput("discard_ca1", pia_ca1, 0);

        // Write and read eligible together: write goes first.
        pia_pb = 7'h55;
        fifo_d_in = 8'h42;
        pia_cb2 = 1'b1;
        fifo_rxf_n = 1'b0;
        fifo_txe_n = 1'b0;
        first_wr = -1;
        first_rd = -1;
        overlap = 0;
        for (int i = 1; i <= 40; i++) begin
            applyStimulus(1);
            if (fifo_wr_n === 1'b0 && first_wr < 0) first_wr = i;
            if (fifo_rd_n === 1'b0 && first_rd < 0) begin
                first_rd = i;
                fifo_rxf_n = 1'b1;
            end
            if (fifo_wr_n === 1'b0 && fifo_rd_n === 1'b0) overlap++;
        end
        wr_first = (first_wr > 0) && (first_rd > first_wr);
        checkOutput("arb_write_first", wr_first, 1);
        checkOutput("arb_no_overlap", overlap, 0);
        pia_cb2 = 1'b0;
        fifo_txe_n = 1'b1;
        applyStimulus(8);
        checkOutput("arb_pa", pia_pa, 8'h42);
        checkOutput("arb_level", rx_level, 1);
        checkOutput("arb_d_out", fifo_d_out, 8'h55);
        checkOutput("arb_da", pia_da, 0);

        // Second display strobe during a write is dropped.
        pia_pb = 7'h12;
        pia_cb2 = 1'b1;
        fifo_txe_n = 1'b0;
        applyStimulus(2);
        pia_cb2 = 1'b0;
        n = 0;
        while (fifo_wr_n !== 1'b0 && n < 15) begin
            applyStimulus(1);
            n++;
        end
        checkOutput("drop_wr_started", fifo_wr_n, 0);
        pia_pb = 7'h34;
        pia_cb2 = 1'b1;
        pulses = 1;
        prev = fifo_wr_n;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1);
            if (i == 2) pia_cb2 = 1'b0;
            if (prev === 1'b1 && fifo_wr_n === 1'b0) pulses++;
            prev = fifo_wr_n;
        end
        checkOutput("drop_single_pulse", pulses, 1);
        checkOutput("drop_d_out", fifo_d_out, 8'h12);
        checkOutput("drop_da", pia_da, 0);
        fifo_txe_n = 1'b1;
        applyStimulus(3);

        // Reset aborts a read in progress.
        fifo_d_in = 8'h20;
        fifo_rxf_n = 1'b0;
        n = 0;
        while (fifo_rd_n !== 1'b0 && n < 20) begin
            applyStimulus(1);
            n++;
        end
        checkOutput("abort_read_started", fifo_rd_n, 0);
        reset = 1'b1;
        fifo_rxf_n = 1'b1;
        applyStimulus(1);
        checkOutput("abort_rd_n", fifo_rd_n, 1);
        checkOutput("abort_level", rx_level, 0);
        checkOutput("abort_ca1", pia_ca1, 0);
        checkOutput("abort_pa", pia_pa, 0);
        reset = 1'b0;
        applyStimulus(6);
        checkOutput("abort_stays_idle", fifo_rd_n, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
